// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_pkg
// Brief   : Shared types and frame-field constants for the SPI register responder.
// Revision: 1.0
// ============================================================================
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int RW_BIT     = 15;
    localparam int LEN_MSB    = 14;
    localparam int LEN_LSB    = 13;
    localparam int ADDR_MSB   = 12;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;
    localparam int CMD_BITS   = 8;

    localparam logic [4:0] ID_ADDR    = 5'h1F;
    localparam logic [3:0] CMD_LAST   = 4'd7;
    localparam logic [3:0] FRAME_LAST = 4'd15;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : spi_edge_sync
// Brief   : N-stage synchronizer with registered rise/fall pulses and aligned level.
// Revision: 1.0
// ============================================================================
module spi_edge_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{INIT}};
            prev <= INIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end

    // level is taken from the same stage as the pulses so they line up
    assign level = prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_reg_responder
// Brief   : Oversampled SPI target for the 16-bit R/W-len-addr-data register protocol.
// Revision: 1.0
// ============================================================================
module spi_reg_responder #(
    parameter logic [7:0] CHIP_ID     = 8'h83,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       spi_scs_in,
    input  logic       spi_sck_in,
    input  logic       spi_sdi_in,
    output logic       spi_sdo_out,
    output logic       spi_sdo_oe_out,
    input  logic [4:0] host_addr_in,
    output logic [7:0] host_data_out,
    output logic       wr_strobe_out,
    output logic [4:0] wr_addr_out,
    output logic [7:0] wr_data_out,
    output logic       frame_err_out
);
    import spi_reg_pkg::*;

    logic scs_level, scs_rise, scs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic sdi_level, sdi_rise, sdi_fall;
    logic unused_edges;

    // SCS chain resets to "selected" so a frame already running at reset release
    // never produces a fall and cannot be resumed.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_scs_sync (
        .clk(clk_in), .rst(rst_in), .din(spi_scs_in),
        .level(scs_level), .rise(scs_rise), .fall(scs_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk(clk_in), .rst(rst_in), .din(spi_sck_in),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sdi_sync (
        .clk(clk_in), .rst(rst_in), .din(spi_sdi_in),
        .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
    );

    assign unused_edges = &{scs_level, sck_level, sdi_rise, sdi_fall};

    state_t     state, state_next;
    logic [3:0] bit_cnt;
    logic [7:0] instr, instr_next;
    logic [7:0] wdata, wdata_next;
    logic [7:0] rd_shift;
    logic       is_read;
    logic [4:0] addr, addr_next;
    logic       err_seen;
    logic [7:0] regs [0:31];

    logic       last_rise;
    logic       clr_frame, cnt_inc, shift_cmd, load_cmd, shift_wdata;
    logic       commit, drive_bit, frame_err, end_frame;

    assign instr_next = {instr[6:0], sdi_level};
    assign wdata_next = {wdata[6:0], sdi_level};
    assign addr_next  = instr_next[ADDR_MSB-CMD_BITS:ADDR_LSB-CMD_BITS];
    assign last_rise  = sck_rise && (bit_cnt == FRAME_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (scs_fall) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (scs_rise)
                    state_next = ST_IDLE;
                else if (sck_rise && bit_cnt == CMD_LAST)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                // the 16th bit completes the frame even if SCS rises alongside it
                if (last_rise)
                    state_next = scs_rise ? ST_IDLE : ST_DONE;
                else if (scs_rise)
                    state_next = ST_IDLE;
            end
            ST_DONE: begin
                if (scs_rise) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_frame   = 1'b0;
        cnt_inc     = 1'b0;
        shift_cmd   = 1'b0;
        load_cmd    = 1'b0;
        shift_wdata = 1'b0;
        commit      = 1'b0;
        drive_bit   = 1'b0;
        frame_err   = 1'b0;
        end_frame   = 1'b0;
        case (state)
            ST_IDLE: begin
                clr_frame = scs_fall;
            end
            ST_CMD: begin
                if (scs_rise) begin
                    frame_err = 1'b1;
                    end_frame = 1'b1;
                end else if (sck_rise) begin
                    shift_cmd = 1'b1;
                    cnt_inc   = 1'b1;
                    load_cmd  = (bit_cnt == CMD_LAST);
                end
            end
            ST_DATA: begin
                cnt_inc     = sck_rise;
                shift_wdata = sck_rise && !is_read;
                commit      = last_rise && !is_read && (addr != ID_ADDR);
                frame_err   = scs_rise && !last_rise;
                end_frame   = scs_rise;
                drive_bit   = sck_fall && is_read && !scs_rise;
            end
            ST_DONE: begin
                end_frame = scs_rise;
                frame_err = sck_rise && !err_seen;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt  <= 4'd0;
            instr    <= 8'h00;
            wdata    <= 8'h00;
            rd_shift <= 8'h00;
            is_read  <= 1'b0;
            addr     <= 5'd0;
            err_seen <= 1'b0;
        end else begin
            if (clr_frame) begin
                bit_cnt  <= 4'd0;
                err_seen <= 1'b0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (frame_err) err_seen <= 1'b1;
            if (shift_cmd) instr <= instr_next;
            if (shift_wdata) wdata <= wdata_next;
            if (load_cmd) begin
                is_read  <= instr_next[RW_BIT-CMD_BITS];
                addr     <= addr_next;
                rd_shift <= (addr_next == ID_ADDR) ? CHIP_ID : regs[addr_next];
            end else if (drive_bit) begin
                rd_shift <= {rd_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
        end else if (commit) begin
            regs[addr] <= wdata_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            spi_sdo_out    <= 1'b0;
            spi_sdo_oe_out <= 1'b0;
            wr_strobe_out  <= 1'b0;
            wr_addr_out    <= 5'd0;
            wr_data_out    <= 8'h00;
            frame_err_out  <= 1'b0;
            host_data_out  <= 8'h00;
        end else begin
            if (end_frame) begin
                spi_sdo_out    <= 1'b0;
                spi_sdo_oe_out <= 1'b0;
            end else if (drive_bit) begin
                spi_sdo_out    <= rd_shift[7];
                spi_sdo_oe_out <= 1'b1;
            end
            wr_strobe_out <= commit;
            if (commit) begin
                wr_addr_out <= addr;
                wr_data_out <= wdata_next;
            end
            frame_err_out <= frame_err;
            host_data_out <= (host_addr_in == ID_ADDR) ? CHIP_ID : regs[host_addr_in];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_reg_responder
// Brief   : Directed bench driving SPI frames into spi_reg_responder.
// Revision: 1.0
// ============================================================================
module tb_spi_reg_responder;

    localparam int HALF = 8;

    logic       clk_in     = 1'b0;
    logic       rst_in     = 1'b1;
    logic       spi_scs_in = 1'b1;
    logic       spi_sck_in = 1'b0;
    logic       spi_sdi_in = 1'b0;
    logic [4:0] host_addr_in = 5'd0;
    logic       spi_sdo_out, spi_sdo_oe_out, wr_strobe_out, frame_err_out;
    logic [4:0] wr_addr_out;
    logic [7:0] wr_data_out, host_data_out;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int leak_cnt = 0;

    logic [15:0] miso;
    logic [15:0] oe_bits;
    logic [24:0] rst_snap;

    spi_reg_responder #(.CHIP_ID(8'h83), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .spi_scs_in(spi_scs_in), .spi_sck_in(spi_sck_in), .spi_sdi_in(spi_sdi_in),
        .spi_sdo_out(spi_sdo_out), .spi_sdo_oe_out(spi_sdo_oe_out),
        .host_addr_in(host_addr_in), .host_data_out(host_data_out),
        .wr_strobe_out(wr_strobe_out), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .frame_err_out(frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (wr_strobe_out) strobe_cnt++;
        if (frame_err_out) err_cnt++;
        if (!spi_sdo_oe_out && spi_sdo_out) leak_cnt++;
    end

    // One initiator frame, CPOL=0/CPHA=0; bits past 16 are sent as 0.
    // rst_bit >= 0 pulses rst_in just before that bit and snapshots the outputs.
    task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_bit);
        miso    = 16'h0;
        oe_bits = 16'h0;
        @(negedge clk_in);
        spi_scs_in = 1'b0;
        repeat (HALF) @(negedge clk_in);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst_in = 1'b1;
                repeat (3) @(negedge clk_in);
                rst_snap = {spi_sdo_out, spi_sdo_oe_out, wr_strobe_out, wr_addr_out,
                            wr_data_out, frame_err_out, host_data_out};
                rst_in = 1'b0;
                repeat (2) @(negedge clk_in);
            end
            spi_sdi_in = (i < 16) ? word[15-i] : 1'b0;
            repeat (HALF) @(negedge clk_in);
            spi_sck_in = 1'b1;
            if (i < 16) begin
                miso    = {miso[14:0], spi_sdo_out};
                oe_bits = {oe_bits[14:0], spi_sdo_oe_out};
            end
            repeat (HALF) @(negedge clk_in);
            spi_sck_in = 1'b0;
        end
        repeat (HALF) @(negedge clk_in);
        spi_scs_in = 1'b1;
        spi_sdi_in = 1'b0;
        repeat (3 * HALF) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        checks++;
        if ({spi_sdo_out, spi_sdo_oe_out, wr_strobe_out, wr_addr_out, wr_data_out,
             frame_err_out, host_data_out} !== 25'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sdo=%b oe=%b stb=%b addr=%h data=%h err=%b host=%h required all 0",
                     spi_sdo_out, spi_sdo_oe_out, wr_strobe_out, wr_addr_out, wr_data_out,
                     frame_err_out, host_data_out);
        end
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_write();
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_frame(16'h0513, 16, -1);
        checks++;
        if (strobe_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL write_strobe_count: got %0d required 1", strobe_cnt - s0);
        end
        checks++;
        if (wr_addr_out !== 5'd5 || wr_data_out !== 8'h13) begin
            errors++;
            $display("FAIL write_addr_data: got %h/%h required 05/13", wr_addr_out, wr_data_out);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL write_no_err: got %0d error pulses required 0", err_cnt - e0);
        end
        checks++;
        if (oe_bits !== 16'h0000) begin
            errors++;
            $display("FAIL write_oe_low: got %h required 0000", oe_bits);
        end
        host_addr_in = 5'd5;
        repeat (2) @(negedge clk_in);
        checks++;
        if (host_data_out !== 8'h13) begin
            errors++;
            $display("FAIL host_read_5: got %h required 13", host_data_out);
        end
    endtask

    task automatic test_read();
        int s0, e0, l0;
        spi_frame(16'h04DF, 16, -1);
        s0 = strobe_cnt;
        e0 = err_cnt;
        l0 = leak_cnt;
        spi_frame(16'h8400, 16, -1);
        checks++;
        if (miso[7:0] !== 8'hDF) begin
            errors++;
            $display("FAIL read_data_4: got %h required DF", miso[7:0]);
        end
        checks++;
        if (oe_bits !== 16'h00FF) begin
            errors++;
            $display("FAIL read_oe_window: got %h required 00FF", oe_bits);
        end
        checks++;
        if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL read_side_effects: got strobes=%0d errs=%0d required 0/0",
                     strobe_cnt - s0, err_cnt - e0);
        end
        checks++;
        if (spi_sdo_oe_out !== 1'b0 || leak_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL read_oe_release: got oe=%b leaks=%0d required 0/0",
                     spi_sdo_oe_out, leak_cnt - l0);
        end
    endtask

    task automatic test_chip_id();
        int s0, e0;
        spi_frame(16'h9F00, 16, -1);
        checks++;
        if (miso[7:0] !== 8'h83) begin
            errors++;
            $display("FAIL chip_id_read: got %h required 83", miso[7:0]);
        end
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_frame(16'h1F55, 16, -1);
        checks++;
        if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL id_write_ignored: got strobes=%0d errs=%0d required 0/0",
                     strobe_cnt - s0, err_cnt - e0);
        end
        spi_frame(16'h9F00, 16, -1);
        checks++;
        if (miso[7:0] !== 8'h83) begin
            errors++;
            $display("FAIL chip_id_after_write: got %h required 83", miso[7:0]);
        end
    endtask

    task automatic test_abort();
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_frame(16'h0A77, 10, -1);
        checks++;
        if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL abort_pulses: got strobes=%0d errs=%0d required 0/1",
                     strobe_cnt - s0, err_cnt - e0);
        end
        host_addr_in = 5'h0A;
        repeat (2) @(negedge clk_in);
        checks++;
        if (host_data_out !== 8'h00) begin
            errors++;
            $display("FAIL abort_reg_untouched: got %h required 00", host_data_out);
        end
        s0 = strobe_cnt;
        spi_frame(16'h0A77, 16, -1);
        repeat (2) @(negedge clk_in);
        checks++;
        if (strobe_cnt - s0 !== 1 || host_data_out !== 8'h77) begin
            errors++;
            $display("FAIL abort_recovery: got strobes=%0d reg=%h required 1/77",
                     strobe_cnt - s0, host_data_out);
        end
    endtask

    task automatic test_overlong();
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_frame(16'h0322, 17, -1);
        checks++;
        if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL overlong_pulses: got strobes=%0d errs=%0d required 1/1",
                     strobe_cnt - s0, err_cnt - e0);
        end
        checks++;
        if (wr_addr_out !== 5'd3 || wr_data_out !== 8'h22) begin
            errors++;
            $display("FAIL overlong_write: got %h/%h required 03/22", wr_addr_out, wr_data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0, e0;
        host_addr_in = 5'd3;
        repeat (2) @(negedge clk_in);
        s0 = strobe_cnt;
        e0 = err_cnt;
        spi_frame(16'h06A5, 16, 12);
        checks++;
        if (rst_snap !== 25'h0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h required 0000000", rst_snap);
        end
        checks++;
        if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL midframe_no_resume: got strobes=%0d errs=%0d required 0/0",
                     strobe_cnt - s0, err_cnt - e0);
        end
        host_addr_in = 5'd6;
        repeat (2) @(negedge clk_in);
        checks++;
        if (host_data_out !== 8'h00) begin
            errors++;
            $display("FAIL midframe_target_reg: got %h required 00", host_data_out);
        end
        s0 = strobe_cnt;
        spi_frame(16'h06A5, 16, -1);
        repeat (2) @(negedge clk_in);
        checks++;
        if (strobe_cnt - s0 !== 1 || wr_addr_out !== 5'd6 || wr_data_out !== 8'hA5 ||
            host_data_out !== 8'hA5) begin
            errors++;
            $display("FAIL post_reset_write: got strobes=%0d addr=%h data=%h reg=%h required 1/06/A5/A5",
                     strobe_cnt - s0, wr_addr_out, wr_data_out, host_data_out);
        end
        host_addr_in = 5'd5;
        repeat (2) @(negedge clk_in);
        checks++;
        if (host_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_clears_regs: got %h required 00", host_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_chip_id();
        test_abort();
        test_overlong();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
